// File: rtl/cp0_ctrl_pkg.sv
// Shared CP0 definitions: register numbers, exception codes and Status/Cause field positions.
package cp0_ctrl_pkg;

  localparam logic [4:0] RegBadVAddr = 5'd8;
  localparam logic [4:0] RegCount    = 5'd9;
  localparam logic [4:0] RegCompare  = 5'd11;
  localparam logic [4:0] RegStatus   = 5'd12;
  localparam logic [4:0] RegCause    = 5'd13;
  localparam logic [4:0] RegEpc      = 5'd14;

  localparam logic [4:0] ExcInt  = 5'h00;
  localparam logic [4:0] ExcAdEL = 5'h04;
  localparam logic [4:0] ExcAdES = 5'h05;
  localparam logic [4:0] ExcSys  = 5'h08;
  localparam logic [4:0] ExcBp   = 5'h09;
  localparam logic [4:0] ExcRi   = 5'h0a;
  localparam logic [4:0] ExcOv   = 5'h0c;

  localparam int unsigned StatusBev   = 22;
  localparam int unsigned StatusImLo  = 8;
  localparam int unsigned StatusExl   = 1;
  localparam int unsigned StatusIe    = 0;
  localparam int unsigned CauseBd     = 31;
  localparam int unsigned CauseTi     = 30;
  localparam int unsigned CauseIpLo   = 8;
  localparam int unsigned CauseExcLo  = 2;

  localparam logic [31:0] StatusReset = 32'h0040_0000;

  // Only address-error exceptions carry a meaningful faulting address.
  function automatic logic is_addr_exc(input logic [4:0] excode);
    return (excode == ExcAdEL) || (excode == ExcAdES);
  endfunction

endpackage

// File: rtl/cp0_ctrl_timer.sv
// CP0 timer: Count with a clock divider, Compare, and the sticky timer-interrupt flag.
module cp0_ctrl_timer #(
  parameter int unsigned COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  logic [1:0]  phase_q, phase_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        ti_q, ti_d;
  logic        tick;

  assign tick = (phase_q == 2'(COUNT_DIV - 1));

  always_comb begin
    phase_d   = tick ? 2'd0 : phase_q + 2'd1;
    count_d   = count_q + {31'b0, tick};
    compare_d = compare_q;
    ti_d      = ti_q;
    if (count_we) begin
      count_d = wdata;
      phase_d = 2'd0;
    end
    if (count_q == compare_q) begin
      ti_d = 1'b1;
    end
    // A Compare write acknowledges the timer and beats a simultaneous match.
    if (compare_we) begin
      compare_d = wdata;
      ti_d      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q   <= 2'd0;
      count_q   <= 32'd0;
      compare_q <= 32'd0;
      ti_q      <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
    end
  end

  assign count   = count_q;
  assign compare = compare_q;
  assign ti      = ti_q;

endmodule

// File: rtl/cp0_ctrl.sv
// CP0 register file beside WB: arbitrates exception/eret/mtc0 updates, serves mfc0 and raises int_req.
module cp0_ctrl
  import cp0_ctrl_pkg::*;
#(
  parameter int unsigned COUNT_DIV = 2,
  parameter int unsigned HW_INT_W  = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ws_valid,
  input  logic                ws_ex,
  input  logic [4:0]          ws_excode,
  input  logic                ws_bd,
  input  logic [31:0]         ws_pc,
  input  logic [31:0]         ws_badvaddr,
  input  logic                ws_eret,
  input  logic                mtc0_we,
  input  logic [4:0]          cp0_addr,
  input  logic [31:0]         mtc0_wdata,
  input  logic [HW_INT_W-1:0] hw_int,
  output logic [31:0]         cp0_rdata,
  output logic [31:0]         cp0_epc,
  output logic [31:0]         cp0_status,
  output logic [31:0]         cp0_cause,
  output logic                int_req
);

  logic        do_ex, do_eret, do_mtc0;
  logic [7:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [4:0]  exccode_q, exccode_d;
  logic [5:0]  ip_hw_q, ip_hw_d;
  logic [1:0]  ip_sw_q, ip_sw_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] badvaddr_q, badvaddr_d;
  logic        int_req_q, int_req_d;
  logic [31:0] count, compare;
  logic        ti;

  // Fixed priority: ex > eret > mtc0; losers are dropped.
  assign do_ex   = ws_valid & ws_ex;
  assign do_eret = ws_valid & ~ws_ex & ws_eret;
  assign do_mtc0 = ws_valid & ~ws_ex & ~ws_eret & mtc0_we;

  cp0_ctrl_timer #(
    .COUNT_DIV(COUNT_DIV)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .count_we  (do_mtc0 && (cp0_addr == RegCount)),
    .compare_we(do_mtc0 && (cp0_addr == RegCompare)),
    .wdata     (mtc0_wdata),
    .count     (count),
    .compare   (compare),
    .ti        (ti)
  );

  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    exccode_d  = exccode_q;
    ip_sw_d    = ip_sw_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;
    ip_hw_d    = {hw_int[5] | ti, hw_int[4:0]};
    int_req_d  = ie_q & ~exl_q & (|({ip_hw_q, ip_sw_q} & im_q));

    if (do_ex) begin
      exl_d     = 1'b1;
      exccode_d = ws_excode;
      // Nested exceptions keep the original return point.
      if (!exl_q) begin
        epc_d = ws_bd ? ws_pc - 32'd4 : ws_pc;
        bd_d  = ws_bd;
      end
      if (is_addr_exc(ws_excode)) begin
        badvaddr_d = ws_badvaddr;
      end
    end else if (do_eret) begin
      exl_d = 1'b0;
    end else if (do_mtc0) begin
      unique case (cp0_addr)
        RegStatus: begin
          im_d  = mtc0_wdata[15:8];
          exl_d = mtc0_wdata[StatusExl];
          ie_d  = mtc0_wdata[StatusIe];
        end
        RegCause: ip_sw_d = mtc0_wdata[9:8];
        RegEpc:   epc_d   = mtc0_wdata;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      im_q       <= 8'd0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      exccode_q  <= 5'd0;
      ip_hw_q    <= 6'd0;
      ip_sw_q    <= 2'd0;
      epc_q      <= 32'd0;
      badvaddr_q <= 32'd0;
      int_req_q  <= 1'b0;
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      exccode_q  <= exccode_d;
      ip_hw_q    <= ip_hw_d;
      ip_sw_q    <= ip_sw_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
      int_req_q  <= int_req_d;
    end
  end

  assign cp0_status = StatusReset | {16'b0, im_q, 6'b0, exl_q, ie_q};
  assign cp0_cause  = {bd_q, ti, 14'b0, ip_hw_q, ip_sw_q, 1'b0, exccode_q, 2'b0};
  assign cp0_epc    = epc_q;
  assign int_req    = int_req_q;

  always_comb begin
    cp0_rdata = 32'd0;
    case (cp0_addr)
      RegBadVAddr: cp0_rdata = badvaddr_q;
      RegCount:    cp0_rdata = count;
      RegCompare:  cp0_rdata = compare;
      RegStatus:   cp0_rdata = cp0_status;
      RegCause:    cp0_rdata = cp0_cause;
      RegEpc:      cp0_rdata = epc_q;
      default:     cp0_rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_cp0_ctrl.sv
// Bench for cp0_ctrl: directed scenarios plus random traffic against a register-level model.
module tb_cp0_ctrl;

  localparam int unsigned COUNT_DIV = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ws_valid = 1'b0, ws_ex = 1'b0, ws_bd = 1'b0, ws_eret = 1'b0, mtc0_we = 1'b0;
  logic [4:0]  ws_excode = 5'd0, cp0_addr = 5'd0;
  logic [31:0] ws_pc = 32'd0, ws_badvaddr = 32'd0, mtc0_wdata = 32'd0;
  logic [5:0]  hw_int = 6'd0;
  logic [31:0] cp0_rdata, cp0_epc, cp0_status, cp0_cause;
  logic        int_req;

  always #5 clk = ~clk;

  cp0_ctrl #(
    .COUNT_DIV(COUNT_DIV),
    .HW_INT_W (6)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ws_valid   (ws_valid),
    .ws_ex      (ws_ex),
    .ws_excode  (ws_excode),
    .ws_bd      (ws_bd),
    .ws_pc      (ws_pc),
    .ws_badvaddr(ws_badvaddr),
    .ws_eret    (ws_eret),
    .mtc0_we    (mtc0_we),
    .cp0_addr   (cp0_addr),
    .mtc0_wdata (mtc0_wdata),
    .hw_int     (hw_int),
    .cp0_rdata  (cp0_rdata),
    .cp0_epc    (cp0_epc),
    .cp0_status (cp0_status),
    .cp0_cause  (cp0_cause),
    .int_req    (int_req)
  );

  typedef struct {
    logic        rst, valid, ex, bd, eret, mtc0;
    logic [4:0]  excode, addr;
    logic [31:0] pc, badv, wdata;
    logic [5:0]  hw;
  } stim_t;

  typedef struct {
    logic [31:0] status, cause, epc, rdata;
    logic        int_req;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err = 0;

  // Architectural model state
  logic [7:0]  m_im, m_ip;
  logic        m_exl, m_ie, m_bd, m_ti, m_int_req;
  logic [4:0]  m_exc;
  logic [31:0] m_epc, m_badv, m_count, m_compare;
  int unsigned m_since;

  logic [4:0] addr_tab[7] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd3};
  logic [4:0] exc_tab[7]  = '{5'h00, 5'h04, 5'h05, 5'h08, 5'h09, 5'h0a, 5'h0c};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] m_status_word();
    return 32'h0040_0000 | {16'b0, m_im, 6'b0, m_exl, m_ie};
  endfunction

  function automatic logic [31:0] m_cause_word();
    return {m_bd, m_ti, 14'b0, m_ip, 1'b0, m_exc, 2'b0};
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd8:    return m_badv;
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return m_status_word();
      5'd13:   return m_cause_word();
      5'd14:   return m_epc;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_im = 8'd0; m_ip = 8'd0; m_exl = 1'b0; m_ie = 1'b0; m_bd = 1'b0; m_ti = 1'b0;
    m_int_req = 1'b0; m_exc = 5'd0; m_epc = 32'd0; m_badv = 32'd0;
    m_count = 32'd0; m_compare = 32'd0; m_since = 0;
  endtask

  // Advance the model across one clock edge given that cycle's inputs.
  task automatic model_step(input stim_t s);
    logic        ex, er, mt, o_exl, o_ti;
    logic [31:0] o_count, o_compare;
    if (s.rst) begin
      model_reset();
      return;
    end
    ex = s.valid && s.ex;
    er = s.valid && !s.ex && s.eret;
    mt = s.valid && !s.ex && !s.eret && s.mtc0;
    o_exl = m_exl; o_ti = m_ti; o_count = m_count; o_compare = m_compare;

    m_int_req = m_ie && !m_exl && ((m_ip & m_im) != 8'd0);
    m_ip[7:2] = {s.hw[5] | o_ti, s.hw[4:0]};

    m_since++;
    if (m_since % COUNT_DIV == 0) m_count = o_count + 1;
    if (o_count == o_compare) m_ti = 1'b1;

    if (ex) begin
      m_exl = 1'b1;
      m_exc = s.excode;
      if (!o_exl) begin
        m_epc = s.bd ? s.pc - 4 : s.pc;
        m_bd  = s.bd;
      end
      if (s.excode == 5'h04 || s.excode == 5'h05) m_badv = s.badv;
    end else if (er) begin
      m_exl = 1'b0;
    end else if (mt) begin
      case (s.addr)
        5'd9:  begin m_count = s.wdata; m_since = 0; end
        5'd11: begin m_compare = s.wdata; m_ti = 1'b0; end
        5'd12: begin m_im = s.wdata[15:8]; m_exl = s.wdata[1]; m_ie = s.wdata[0]; end
        5'd13: m_ip[1:0] = s.wdata[9:8];
        5'd14: m_epc = s.wdata;
        default: ;
      endcase
    end
  endtask

  // Drive one cycle of stimulus and queue the state expected after the next edge.
  task automatic step(input stim_t s);
    exp_t e;
    @(negedge clk);
    reset = s.rst; ws_valid = s.valid; ws_ex = s.ex; ws_excode = s.excode; ws_bd = s.bd;
    ws_pc = s.pc; ws_badvaddr = s.badv; ws_eret = s.eret; mtc0_we = s.mtc0;
    cp0_addr = s.addr; mtc0_wdata = s.wdata; hw_int = s.hw;
    model_step(s);
    e.status = m_status_word(); e.cause = m_cause_word(); e.epc = m_epc;
    e.rdata = m_read(s.addr); e.int_req = m_int_req;
    exp_q.push_back(e);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  function automatic stim_t idle(input logic [4:0] a, input logic [5:0] hw);
    stim_t s;
    s.rst = 1'b0; s.valid = 1'b0; s.ex = 1'b0; s.bd = 1'b0; s.eret = 1'b0; s.mtc0 = 1'b0;
    s.excode = 5'd0; s.addr = a; s.pc = 32'd0; s.badv = 32'd0; s.wdata = 32'd0; s.hw = hw;
    return s;
  endfunction

  function automatic stim_t mtc0(input logic [4:0] a, input logic [31:0] d, input logic [5:0] hw);
    stim_t s = idle(a, hw);
    s.valid = 1'b1; s.mtc0 = 1'b1; s.wdata = d;
    return s;
  endfunction

  function automatic stim_t exc(input logic [4:0] code, input logic bd, input logic [31:0] pc,
                                input logic [31:0] badv, input logic [4:0] a);
    stim_t s = idle(a, 6'd0);
    s.valid = 1'b1; s.ex = 1'b1; s.excode = code; s.bd = bd; s.pc = pc; s.badv = badv;
    return s;
  endfunction

  // Monitor: compares every queued expectation right after its edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("mon_status", cp0_status, e.status);
        check("mon_cause", cp0_cause, e.cause);
        check("mon_epc", cp0_epc, e.epc);
        check("mon_rdata", cp0_rdata, e.rdata);
        check("mon_int_req", {31'b0, int_req}, {31'b0, e.int_req});
      end
    end
  end

  initial begin
    stim_t s;
    logic [5:0] hw_r;
    bit found;
    model_reset();

    // Reset and read back every register
    s = idle(5'd12, 6'd0); s.rst = 1'b1;
    step(s); step(s);
    after_edge();
    check("rst_status", cp0_rdata, 32'h0040_0000);
    check("rst_cause", cp0_cause, 32'd0);
    check("rst_int_req", {31'b0, int_req}, 32'd0);
    for (int i = 0; i < 7; i++) step(idle(addr_tab[i], 6'd0));

    // Exception in a delay slot with address error
    step(exc(5'h04, 1'b1, 32'hBFC0_0100, 32'h1234_5671, 5'd8));
    after_edge();
    check("ex_epc", cp0_epc, 32'hBFC0_00FC);
    check("ex_cause_bd_code", cp0_cause & 32'h8000_007C, 32'h8000_0010);
    check("ex_status", cp0_status, 32'h0040_0002);
    check("ex_badvaddr", cp0_rdata, 32'h1234_5671);
    step(exc(5'h0c, 1'b0, 32'h8000_1000, 32'hDEAD_BEEF, 5'd8));
    after_edge();
    check("nested_epc", cp0_epc, 32'hBFC0_00FC);
    check("nested_badvaddr", cp0_rdata, 32'h1234_5671);

    // ex beats a same-cycle mtc0, then eret
    s = exc(5'h08, 1'b0, 32'h8000_2000, 32'd0, 5'd12);
    s.mtc0 = 1'b1; s.wdata = 32'h0000_FF01;
    step(s);
    after_edge();
    check("ex_drops_mtc0", cp0_status, 32'h0040_0002);
    s = idle(5'd12, 6'd0); s.valid = 1'b1; s.eret = 1'b1;
    step(s);
    after_edge();
    check("eret_status", cp0_status, 32'h0040_0000);

    // Timer interrupt
    step(mtc0(5'd11, 32'd5, 6'd0));
    step(mtc0(5'd9, 32'd0, 6'd0));
    step(mtc0(5'd12, 32'h0000_8001, 6'd0));
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step(idle(5'd13, 6'd0));
      after_edge();
      found = int_req;
    end
    check("timer_int_seen", {31'b0, found}, 32'd1);
    check("timer_ti_bit", cp0_cause & 32'h4000_8000, 32'h4000_8000);
    step(mtc0(5'd11, 32'h0000_1000, 6'd0));
    step(idle(5'd13, 6'd0));
    step(idle(5'd13, 6'd0));
    after_edge();
    check("timer_int_drop", {31'b0, int_req}, 32'd0);

    // External interrupt line 0 -> IP2
    step(mtc0(5'd12, 32'h0000_0401, 6'b000001));
    step(idle(5'd13, 6'b000001));
    step(idle(5'd13, 6'b000001));
    after_edge();
    check("hw_ip2", cp0_cause & 32'h0000_0400, 32'h0000_0400);
    check("hw_int_req", {31'b0, int_req}, 32'd1);
    step(mtc0(5'd12, 32'h0000_0403, 6'b000001));
    step(idle(5'd13, 6'b000001));
    after_edge();
    check("exl_masks", {31'b0, int_req}, 32'd0);

    // Count wrap
    step(mtc0(5'd9, 32'hFFFF_FFFF, 6'd0));
    step(idle(5'd9, 6'd0));
    step(idle(5'd9, 6'd0));
    after_edge();
    check("count_wrap", cp0_rdata, 32'd0);

    // Reset mid-sequence
    step(mtc0(5'd11, 32'd5, 6'd0));
    step(mtc0(5'd9, 32'd0, 6'd0));
    step(mtc0(5'd12, 32'h0000_8001, 6'd0));
    for (int i = 0; i < 4; i++) step(idle(5'd9, 6'd0));
    s = idle(5'd9, 6'd0); s.rst = 1'b1;
    step(s);
    after_edge();
    check("midrst_count", cp0_rdata, 32'd0);
    check("midrst_status", cp0_status, 32'h0040_0000);
    check("midrst_epc", cp0_epc, 32'd0);

    // Random traffic
    hw_r = 6'd0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) hw_r = 6'($urandom);
      s = idle(addr_tab[$urandom_range(0, 6)], hw_r);
      if ($urandom_range(0, 7) == 0) s.addr = 5'($urandom);
      s.rst    = ($urandom_range(0, 299) == 0);
      s.valid  = ($urandom_range(0, 3) != 0);
      s.ex     = ($urandom_range(0, 7) == 0);
      s.excode = exc_tab[$urandom_range(0, 6)];
      s.bd     = 1'($urandom);
      s.pc     = $urandom & 32'hFFFF_FFFC;
      s.badv   = $urandom;
      s.eret   = ($urandom_range(0, 7) == 0);
      s.mtc0   = ($urandom_range(0, 2) == 0);
      s.wdata  = (s.addr == 5'd9 || s.addr == 5'd11) ? 32'($urandom_range(0, 40)) : $urandom;
      step(s);
    end

    step(idle(5'd0, 6'd0));
    repeat (3) @(posedge clk);
    #2;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
